// File: rtl/drawbridge_pkg.sv
// drawbridge_pkg: shared state encoding, on/off levels and timer sizing for drawbridge_ctrl.
package drawbridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WARN  = 3'd1,
        CLEAR = 3'd2,
        RAISE = 3'd3,
        OPEN  = 3'd4,
        LOWER = 3'd5
    } state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    function automatic int timerWidth(int warnCyc, int moveCyc, int clearTo);
        int m;
        m = warnCyc > moveCyc ? warnCyc : moveCyc;
        m = m > clearTo ? m : clearTo;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lane_car_counter.sv
// lane_car_counter: multi-lane saturating car counter with a one-cycle saturation-fault pulse.
module lane_car_counter #(
    parameter int N_LANES = 2,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_LANES-1:0] i_carIn,
    input  logic [N_LANES-1:0] i_carOut,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_satFault
);

    localparam int SW = CNT_W + 2;

    logic [SW-1:0]    sum;
    logic             under;
    logic             over;
    logic [CNT_W-1:0] clamped;

    // Two guard bits: the MSB flags a negative result, the next one an overflow.
    always_comb begin
        sum        = {2'b00, o_count} + SW'($countones(i_carIn)) - SW'($countones(i_carOut));
        under      = sum[SW-1];
        over       = !under && sum[SW-2];
        clamped    = under ? '0 : over ? '1 : sum[CNT_W-1:0];
        o_satFault = under || over;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) o_count <= '0;
        else         o_count <= clamped;
    end

endmodule

// File: rtl/drawbridge_ctrl.sv
// drawbridge_ctrl: timed Moore drawbridge sequencer (warn, clear, raise, open, lower) with sticky fault.
// Defining DRAWBRIDGE_OPEN_STATS_EN adds o_openCount, a wrapping count of RAISE->OPEN transitions.
module drawbridge_ctrl
    import drawbridge_pkg::*;
#(
    parameter int N_LANES  = 2,
    parameter int CNT_W    = 8,
    parameter int WARN_CYC = 16,
    parameter int MOVE_CYC = 32,
    parameter int CLEAR_TO = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_LANES-1:0] i_carIn,
    input  logic [N_LANES-1:0] i_carOut,
    input  logic               i_boatClose,
    input  logic               i_boatHere,
    output logic               o_carBarrier,
    output logic               o_alert,
    output logic               o_bridge_s,
    output logic               o_moving,
    output logic               o_fault,
    output logic [CNT_W-1:0]   o_carCount,
`ifdef DRAWBRIDGE_OPEN_STATS_EN
    output logic [15:0]        o_openCount,
`endif
    output logic [2:0]         machine_state
);

    localparam int TW = timerWidth(WARN_CYC, MOVE_CYC, CLEAR_TO);
    localparam logic [TW-1:0] WARN_LD  = TW'(WARN_CYC - 1);
    localparam logic [TW-1:0] MOVE_LD  = TW'(MOVE_CYC - 1);
    localparam logic [TW-1:0] CLEAR_LD = TW'(CLEAR_TO - 1);

    state_t        state;
    state_t        nextState;
    logic [TW-1:0] timer;
    logic [TW-1:0] loadVal;
    logic          boat;
    logic          satFault;
    logic          newFault;

    lane_car_counter #(.N_LANES(N_LANES), .CNT_W(CNT_W)) u_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_carIn    (i_carIn),
        .i_carOut   (i_carOut),
        .o_count    (o_carCount),
        .o_satFault (satFault)
    );

    assign boat = i_boatClose | i_boatHere;

    // CLEAR: an empty bridge wins over both boat drop and timeout.
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = boat ? WARN : IDLE;
            WARN:    nextState = !boat ? IDLE : (timer == '0 ? CLEAR : WARN);
            CLEAR:   nextState = o_carCount == '0 ? RAISE : (!boat ? IDLE : CLEAR);
            RAISE:   nextState = timer == '0 ? OPEN : RAISE;
            OPEN:    nextState = boat ? OPEN : LOWER;
            LOWER:   nextState = boat ? RAISE : (timer == '0 ? IDLE : LOWER);
            default: nextState = IDLE;
        endcase
        loadVal  = nextState == WARN ? WARN_LD :
                   nextState == CLEAR ? CLEAR_LD :
                   (nextState == RAISE || nextState == LOWER) ? MOVE_LD : '0;
        newFault = satFault
                || (state == CLEAR && nextState == CLEAR && timer == '0)
                || ((state == RAISE || state == OPEN || state == LOWER) && |i_carIn);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            timer   <= '0;
            o_fault <= OFF;
        end else begin
            state   <= nextState;
            timer   <= nextState != state ? loadVal : (timer == '0 ? '0 : timer - TW'(1));
            o_fault <= o_fault | newFault;
        end
    end

`ifdef DRAWBRIDGE_OPEN_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)                                   o_openCount <= '0;
        else if (state == RAISE && nextState == OPEN)  o_openCount <= o_openCount + 16'd1;
    end
`endif

    assign o_carBarrier  = state inside {CLEAR, RAISE, OPEN, LOWER};
    assign o_alert       = state inside {WARN, CLEAR, RAISE, LOWER};
    assign o_bridge_s    = state inside {RAISE, OPEN, LOWER};
    assign o_moving      = state inside {RAISE, LOWER};
    assign machine_state = state;

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// tb_drawbridge_ctrl: directed stimulus, per-cycle comparison against an elapsed-time phase model.
// Covers the DRAWBRIDGE_OPEN_STATS_EN port when that macro is defined.
module tb_drawbridge_ctrl;

    localparam int N_LANES  = 2;
    localparam int CNT_W    = 4;
    localparam int WARN_CYC = 4;
    localparam int MOVE_CYC = 8;
    localparam int CLEAR_TO = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic               i_clk = 0;
    logic               i_reset = 1;
    logic [N_LANES-1:0] i_carIn = '0;
    logic [N_LANES-1:0] i_carOut = '0;
    logic               i_boatClose = 0;
    logic               i_boatHere = 0;
    logic               o_carBarrier, o_alert, o_bridge_s, o_moving, o_fault;
    logic [CNT_W-1:0]   o_carCount;
    logic [2:0]         machine_state;
`ifdef DRAWBRIDGE_OPEN_STATS_EN
    logic [15:0]        o_openCount;
`endif

    drawbridge_ctrl #(
        .N_LANES(N_LANES), .CNT_W(CNT_W), .WARN_CYC(WARN_CYC), .MOVE_CYC(MOVE_CYC), .CLEAR_TO(CLEAR_TO)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_carIn      (i_carIn),
        .i_carOut     (i_carOut),
        .i_boatClose  (i_boatClose),
        .i_boatHere   (i_boatHere),
        .o_carBarrier (o_carBarrier),
        .o_alert      (o_alert),
        .o_bridge_s   (o_bridge_s),
        .o_moving     (o_moving),
        .o_fault      (o_fault),
        .o_carCount   (o_carCount),
`ifdef DRAWBRIDGE_OPEN_STATS_EN
        .o_openCount  (o_openCount),
`endif
        .machine_state(machine_state)
    );

    always #5 i_clk = ~i_clk;

    int   errors = 0;
    int   checks = 0;
    bit   armed = 0;
    int   mPhase = 0;
    int   mElapsed = 0;
    int   mCount = 0;
    bit   mFault = 0;
    logic [15:0] mOpen = '0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // {barrier, alert, bridge, moving} for each phase of the bridge sequence.
    function automatic int expOut(int p);
        case (p)
            1:       return 4'b0100;
            2:       return 4'b1100;
            3:       return 4'b1111;
            4:       return 4'b1010;
            5:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Phases: 0 idle, 1 warn, 2 clear, 3 raise, 4 open, 5 lower; mElapsed counts cycles in the phase.
    always @(posedge i_clk) begin
        int raw, np;
        bit boat;
        if (i_reset) begin
            mPhase = 0; mElapsed = 0; mCount = 0; mFault = 0; mOpen = '0;
        end else begin
            boat = i_boatClose | i_boatHere;
            raw  = mCount + $countones(i_carIn) - $countones(i_carOut);
            np   = mPhase;
            case (mPhase)
                0: if (boat) np = 1;
                1: if (!boat) np = 0; else if (mElapsed + 1 >= WARN_CYC) np = 2;
                2: if (mCount == 0) np = 3; else if (!boat) np = 0;
                   else if (mElapsed + 1 >= CLEAR_TO) mFault = 1;
                3: if (mElapsed + 1 >= MOVE_CYC) np = 4;
                4: if (!boat) np = 5;
                5: if (boat) np = 3; else if (mElapsed + 1 >= MOVE_CYC) np = 0;
                default: np = 0;
            endcase
            if (mPhase >= 3 && i_carIn != '0) mFault = 1;
            if (raw < 0 || raw > CNT_MAX) mFault = 1;
            mCount = raw < 0 ? 0 : (raw > CNT_MAX ? CNT_MAX : raw);
            if (mPhase == 3 && np == 4) mOpen = mOpen + 16'd1;
            mElapsed = (np == mPhase) ? mElapsed + 1 : 0;
            mPhase = np;
        end
    end

    always @(negedge i_clk) begin
        if (armed) begin
            check("state", int'(machine_state), mPhase);
            check("outputs", int'({o_carBarrier, o_alert, o_bridge_s, o_moving}), expOut(mPhase));
            check("count", int'(o_carCount), mCount);
            check("fault", int'(o_fault), int'(mFault));
`ifdef DRAWBRIDGE_OPEN_STATS_EN
            check("openCount", int'(o_openCount), int'(mOpen));
`endif
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic doReset();
        i_reset = 1; i_carIn = '0; i_carOut = '0; i_boatClose = 0; i_boatHere = 0;
        step(1);
        i_reset = 0;
    endtask

    // Boat arrives at an empty bridge and the bridge runs up to OPEN (14 cycles).
    task automatic runToOpen();
        i_boatClose = 1;
        step(14);
        check("lit open", int'(machine_state), 4);
    endtask

    task automatic closeFromOpen();
        i_boatClose = 0; i_boatHere = 0;
        step(1 + MOVE_CYC);
        check("lit idle after lower", int'(machine_state), 0);
    endtask

    initial begin
        step(2);
        armed = 1;
        i_reset = 0;
        check("lit reset state", int'(machine_state), 0);
        check("lit reset outs", int'({o_carBarrier, o_alert, o_bridge_s, o_moving, o_fault}), 0);
        check("lit reset count", int'(o_carCount), 0);

        // Full cycle
        i_boatClose = 1;
        step(1); check("lit warn t0+1", int'(machine_state), 1);
        step(4); check("lit clear t0+5", int'(machine_state), 2);
        step(1); check("lit raise t0+6", int'(machine_state), 3);
        check("lit moving", int'(o_moving), 1);
        step(7); check("lit still raising", int'(o_moving), 1);
        step(1); check("lit open t0+14", int'(machine_state), 4);
        i_boatClose = 0; i_boatHere = 1;
        step(3); check("lit open via boatHere", int'(machine_state), 4);
        i_boatHere = 0;
        step(1); check("lit lower", int'(machine_state), 5);
        step(7); check("lit lower still", int'(o_moving), 1);
        step(1); check("lit idle outs", int'({o_carBarrier, o_alert, o_bridge_s, o_moving}), 0);

        // Clearance with cars on the bridge
        doReset();
        i_carIn = 2'b11; step(1);
        i_carIn = 2'b01; step(1);
        i_carIn = 2'b00;
        check("lit count 3", int'(o_carCount), 3);
        i_boatClose = 1;
        step(5 + 3); check("lit hold clear", int'(machine_state), 2);
        i_carOut = 2'b01;
        step(3); check("lit count 0", int'(o_carCount), 0);
        check("lit still clear", int'(machine_state), 2);
        i_carOut = 2'b00;
        step(1); check("lit raise after clear", int'(machine_state), 3);
        step(MOVE_CYC);
        closeFromOpen();

        // Clearance timeout
        doReset();
        i_carIn = 2'b01; step(1); i_carIn = 2'b00;
        i_boatClose = 1;
        step(5); check("lit clear entered", int'(machine_state), 2);
        step(15); check("lit no fault yet", int'(o_fault), 0);
        step(1); check("lit timeout fault", int'(o_fault), 1);
        check("lit stays clear", int'(machine_state), 2);
        step(4);

        // Counter saturation and cancellation
        doReset();
        i_carIn = 2'b11; step(8);
        check("lit saturated", int'(o_carCount), 15);
        check("lit overflow fault", int'(o_fault), 1);
        i_carIn = 2'b01; i_carOut = 2'b01; step(1);
        check("lit cancel", int'(o_carCount), 15);
        doReset();
        i_carOut = 2'b01; step(1); i_carOut = 2'b00;
        check("lit underflow count", int'(o_carCount), 0);
        check("lit underflow fault", int'(o_fault), 1);

        // Abort in WARN
        doReset();
        i_boatClose = 1; step(1);
        check("lit abort warn", int'(machine_state), 1);
        i_boatClose = 0; step(1);
        check("lit abort idle", int'(machine_state), 0);
        check("lit barrier up", int'(o_carBarrier), 0);

        // Reversal in LOWER
        doReset();
        runToOpen();
        i_boatClose = 0; step(3);
        check("lit lowering", int'(machine_state), 5);
        i_boatClose = 1; step(1);
        check("lit reraise", int'(machine_state), 3);
        step(7); check("lit full travel", int'(machine_state), 3);
        step(1); check("lit reopen", int'(machine_state), 4);

        // Intrusion in OPEN, then reset
        i_carIn = 2'b01; step(1); i_carIn = 2'b00;
        check("lit intrusion fault", int'(o_fault), 1);
        check("lit intrusion count", int'(o_carCount), 1);
        i_reset = 1; step(1);
        check("lit reset mid-open", int'({machine_state, o_carBarrier, o_alert, o_bridge_s, o_moving, o_fault}), 0);
        check("lit reset count 0", int'(o_carCount), 0);
        i_reset = 0; i_boatClose = 0; step(2);

`ifdef DRAWBRIDGE_OPEN_STATS_EN
        doReset();
        for (int k = 0; k < 3; k++) begin
            runToOpen();
            closeFromOpen();
        end
        check("lit three openings", int'(o_openCount), 3);
        force dut.o_openCount = 16'hFFFF;
        mOpen = 16'hFFFF;
        step(1);
        release dut.o_openCount;
        runToOpen();
        check("lit open wrap", int'(o_openCount), 0);
        closeFromOpen();
`endif

        armed = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
